// File: rtl/imm_extend.sv
// Immediate-extension stage: sign/zero/branch-scaled extension of a narrow immediate,
// with prefix ops that accumulate upper bits consumed by the next non-prefix immediate.
module imm_extend #(
  parameter int unsigned IN_W  = 6,
  parameter int unsigned OUT_W = 16,
  localparam int unsigned PFX_W = OUT_W - IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [IN_W-1:0]  in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             pfx_active
);

  if (IN_W < 1 || OUT_W < 2 * IN_W) begin : g_bad_params
    $error("imm_extend: requires IN_W >= 1 and OUT_W >= 2*IN_W");
  end

  typedef enum logic [1:0] {
    MODE_SIGN  = 2'b00,
    MODE_ZERO  = 2'b01,
    MODE_SCALE = 2'b10,
    MODE_PFX   = 2'b11
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PFX  = 1'b1
  } state_e;

  state_e           state;
  mode_e            mode;
  logic [PFX_W-1:0] pfx;
  logic [PFX_W-1:0] pfx_next;
  logic [OUT_W-1:0] base;
  logic [OUT_W-1:0] result;
  logic             accept;

  assign mode       = mode_e'(in_mode);
  assign in_ready   = !flush && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign pfx_active = (state == S_PFX);

  always_comb begin
    base     = '0;
    pfx_next = '0;
    // Chained prefixes keep the low bits of {pfx, imm}; this also covers PFX_W == IN_W.
    if (state == S_PFX) pfx_next = PFX_W'({pfx, in_imm});
    else                pfx_next = PFX_W'($signed(in_imm));

    if (state == S_PFX)          base = {pfx, in_imm};
    else if (mode == MODE_ZERO)  base = OUT_W'(in_imm);
    else                         base = OUT_W'($signed(in_imm));

    result = (mode == MODE_SCALE) ? {base[OUT_W-2:0], 1'b0} : base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pfx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      pfx       <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      if (mode == MODE_PFX) begin
        // Accept implies the output slot is empty or draining, so it empties here.
        pfx       <= pfx_next;
        state     <= S_PFX;
        out_valid <= 1'b0;
      end else begin
        out_data  <= result;
        out_valid <= 1'b1;
        pfx       <= '0;
        state     <= S_IDLE;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_extend.sv
// Directed self-checking bench for imm_extend with default parameters.
module tb_imm_extend;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [5:0]  in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        pfx_active;

  int n_cmp = 0;
  int n_bad = 0;

  imm_extend #(.IN_W(6), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .pfx_active(pfx_active)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = 2'b00; in_imm = '0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    n_cmp++; if (pfx_active !== 1'b0) begin n_bad++; $display("FAIL reset_pfx_active: got %b want 0", pfx_active); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick(); tick();
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_extend();
    logic [1:0]  modes [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10};
    logic [5:0]  imms  [5] = '{6'h25, 6'h1A, 6'h25, 6'h25, 6'h1F};
    logic [15:0] exps  [5] = '{16'hFFE5, 16'h001A, 16'h0025, 16'hFFCA, 16'h003E};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_mode = modes[i]; in_imm = imms[i];
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exps[i]) begin
        n_bad++;
        $display("FAIL extend[%0d] mode=%b imm=%h: got valid=%b data=%h want valid=1 data=%h",
                 i, modes[i], imms[i], out_valid, out_data, exps[i]);
      end
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL extend_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_prefix();
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 2'b11; in_imm = 6'h3F;
    tick();
    n_cmp++; if (pfx_active !== 1'b1 || out_valid !== 1'b0) begin n_bad++;
      $display("FAIL pfx_load1: pfx_active=%b out_valid=%b want 1/0", pfx_active, out_valid); end
    in_mode = 2'b11; in_imm = 6'h01;
    tick();
    n_cmp++; if (pfx_active !== 1'b1 || out_valid !== 1'b0) begin n_bad++;
      $display("FAIL pfx_load2: pfx_active=%b out_valid=%b want 1/0", pfx_active, out_valid); end
    in_mode = 2'b00; in_imm = 6'h05;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'hF045) begin n_bad++;
      $display("FAIL pfx_consume: valid=%b data=%h want 1/f045", out_valid, out_data); end
    n_cmp++; if (pfx_active !== 1'b0) begin n_bad++; $display("FAIL pfx_cleared: pfx_active=%b want 0", pfx_active); end
    in_mode = 2'b11; in_imm = 6'h01;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || pfx_active !== 1'b1) begin n_bad++;
      $display("FAIL pfx_while_drain: out_valid=%b pfx_active=%b want 0/1", out_valid, pfx_active); end
    in_mode = 2'b10; in_imm = 6'h00;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h0080 || pfx_active !== 1'b0) begin n_bad++;
      $display("FAIL pfx_scaled: valid=%b data=%h pfx=%b want 1/0080/0", out_valid, out_data, pfx_active); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b00; in_imm = 6'h1A;
    tick();
    in_mode = 2'b01; in_imm = 6'h25;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 16'h001A || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h in_ready=%b want 1/001a/0", c, out_valid, out_data, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h0025) begin n_bad++;
      $display("FAIL bp_second: valid=%b data=%h want 1/0025", out_valid, out_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 2'b11; in_imm = 6'h3F;
    tick();
    flush = 1'b1; in_mode = 2'b00; in_imm = 6'h12;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (pfx_active !== 1'b0 || out_valid !== 1'b0) begin n_bad++;
      $display("FAIL flush_state: pfx_active=%b out_valid=%b want 0/0", pfx_active, out_valid); end
    in_valid = 1'b1; in_mode = 2'b00; in_imm = 6'h05;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h0005) begin n_bad++;
      $display("FAIL flush_after: valid=%b data=%h want 1/0005", out_valid, out_data); end
    // Flush must also kill a result that is stalled on backpressure.
    out_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_stalled: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b00; in_imm = 6'h2A;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'hFFEA) begin n_bad++;
      $display("FAIL ar_setup_out: valid=%b data=%h want 1/ffea", out_valid, out_data); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || pfx_active !== 1'b0) begin n_bad++;
      $display("FAIL ar_out_mid: valid=%b data=%h pfx=%b want 0/0000/0", out_valid, out_data, pfx_active); end
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b1; in_mode = 2'b11; in_imm = 6'h07;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (pfx_active !== 1'b1) begin n_bad++; $display("FAIL ar_setup_pfx: pfx_active=%b want 1", pfx_active); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (pfx_active !== 1'b0 || out_valid !== 1'b0) begin n_bad++;
      $display("FAIL ar_pfx_mid: pfx_active=%b out_valid=%b want 0/0", pfx_active, out_valid); end
    #2 rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_mode = 2'b00; in_imm = 6'h20;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'hFFE0) begin n_bad++;
      $display("FAIL ar_resume: valid=%b data=%h want 1/ffe0", out_valid, out_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_extend();
    test_prefix();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_extend.md
# imm_extend

Parametrised immediate-extension stage for the 16-bit datapath: accepts a narrow instruction immediate plus a mode, and returns a full-width operand one cycle later. It supports sign, zero and branch-scaled extension. It also supports a prefix mechanism in which one or more prefix ops accumulate upper bits that the next non-prefix immediate consumes. The block sits between decode and the ALU/branch operand mux and uses valid/ready handshakes on both sides.

## Interface
- IN_W, 6, immediate field width; must satisfy 1 <= IN_W.
- OUT_W, 16, operand width; must satisfy OUT_W >= 2*IN_W.
- PFX_W, OUT_W-IN_W (derived, not overridable), width of the prefix register.

- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  input request.
- in_ready  out  1  input may be accepted this cycle.
- in_mode  in  2  00 sign, 01 zero, 10 sign then <<1, 11 prefix load.
- in_imm  in  IN_W  immediate field.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUT_W  extended operand.
- pfx_active  out  1  prefix register holds unconsumed bits.

## Operation
- **Accept:** an input is accepted when in_valid && in_ready.
- **in_ready:** in_ready = !flush && (!out_valid || out_ready), combinational.
- **State machine:** IDLE (pfx_active=0) and PFX (pfx_active=1).
- **Prefix load from IDLE (mode 11):**
  - pfx <= in_imm sign-extended to PFX_W.
  - Go to PFX.
  - No output is produced.
- **Prefix load in PFX (mode 11):**
  - pfx <= {pfx[PFX_W-IN_W-1:0], in_imm}; upper bits shift out and are discarded.
  - Stay in PFX.
  - No output is produced.
- **Non-prefix op in IDLE:**
  - Mode 00: out_data <= sign-extend(in_imm).
  - Mode 01: out_data <= zero-extend(in_imm).
  - Mode 10: out_data <= sign-extend(in_imm) << 1, truncated to OUT_W.
- **Non-prefix op in PFX:**
  - The base value is {pfx, in_imm}; no extension is applied.
  - Modes 00 and 01 output the base value.
  - Mode 10 outputs the base value << 1, truncated to OUT_W.
  - pfx is cleared to 0 and the state returns to IDLE.
- **Output register:** a non-prefix accept sets out_valid. Otherwise out_valid clears when out_ready is high.
- **Flush:**
  - out_valid <= 0 and the state returns to IDLE (pfx <= 0).
  - No input is accepted in a flush cycle.
  - out_data may keep its old value.
- **Reset:** out_valid=0, out_data=0, pfx=0, pfx_active=0. in_ready reads 1 whenever rst_n is low and flush is low.
- **Width rule:** all arithmetic is unsigned on OUT_W bits. The <<1 drops the MSB and inserts 0 at the LSB.

## Timing
- Latency is 1 cycle: a non-prefix op accepted at edge N gives out_valid=1 and out_data valid after edge N.
- Throughput is 1 result per cycle while out_ready=1; full-rate prefix ops are also allowed.
- **Stall:** while out_valid && !out_ready, out_data and out_valid hold stable and in_ready=0.
- **Simultaneous accept and drain:** when out_ready=1 and a new non-prefix op is accepted in the same cycle, out_valid stays 1 and out_data updates.
- **Prefix accept while draining:** when out_ready=1 and a prefix op is accepted, out_valid falls to 0.
- **Flush priority:** flush overrides in_valid, out_ready and any prefix state in the same cycle.
- **Asynchronous reset:** outputs take their reset values immediately on rst_n falling, independent of clk. Operation resumes on the first edge after rst_n rises.

## Test plan
All scenarios use default parameters (IN_W=6, OUT_W=16).
- **Sign extension:** mode 00 with in_imm=0x25 -> out_data=0xFFE5 one cycle later; mode 00 with 0x1A -> 0x001A.
- **Zero and scaled:** mode 01 with 0x25 -> 0x0025; mode 10 with 0x25 -> 0xFFCA; mode 10 with 0x1F -> 0x003E.
- **Prefix chain:**
  - Mode 11 with 0x3F -> pfx_active=1, no out_valid.
  - Mode 11 with 0x01 -> pfx=0x3C1.
  - Mode 00 with 0x05 -> out_data=0xF045, pfx_active=0.
  - Then mode 11 with 0x01 and mode 10 with 0x00 -> 0x0080.
- **Backpressure:**
  - Hold out_ready=0 for 3 cycles after a result -> out_data stable, in_ready=0, second request held.
  - Raise out_ready -> second result appears next cycle, with no loss or duplication.
- **Flush:**
  - Load prefix 0x3F, then flush with in_valid=1 -> pfx_active=0, out_valid=0, input not taken.
  - Next mode 00 with 0x05 -> 0x0005.
- **Asynchronous reset:**
  - Drop rst_n mid-cycle with out_valid=1 and pfx_active=1 -> out_valid, out_data and pfx_active all go to 0 before the next clk edge.
  - After release, mode 00 with 0x20 -> 0xFFE0.
